// File: rtl/fb_pkg.sv
// Shared constants and types for the sprite line compositor: entity field
// layout, fetch FSM states and the per-slot record held in the line bank.
package fb_pkg;

  localparam int ENTITY_W = 14;
  localparam int ID_LSB   = 10;
  localparam int ID_W     = 4;
  localparam int ORI_LSB  = 8;
  localparam int ORI_W    = 2;
  localparam int LOC_LSB  = 0;
  localparam int LOC_W    = 8;

  localparam logic [3:0] ENTITY_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } fetch_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] column;
    logic       flip;
    logic [7:0] data;
  } slot_t;

endpackage

// File: rtl/line_slot_bank.sv
// Double-buffered sprite slots: shadow slots fill during blanking, the active
// set is swapped in at end of line and drives the registered pixel colour.
module line_slot_bank
  import fb_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int UPSCALE  = 5,
  parameter int TILE_PX  = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int IDX_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shadow_clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  slot_t            wr_slot,
  input  logic             swap,
  input  logic [9:0]       counter_H,
  input  logic [9:0]       counter_V,
  output logic             colour
);

  localparam logic [9:0] TILE_LEN  = 10'(UPSCALE * TILE_PX);
  localparam logic [9:0] UPSCALE_V = 10'(UPSCALE);

  slot_t      shadow [SLOTS];
  slot_t      active [SLOTS];
  logic [3:0] pix_col;
  logic [2:0] pix_idx;
  logic       found;
  logic       pix_next;

  assign pix_col = 4'(counter_H / TILE_LEN);
  assign pix_idx = 3'((counter_H % TILE_LEN) / UPSCALE_V);

  // Lowest slot index wins any overlap; no transparency, so a 0 bit is black.
  always_comb begin
    found    = 1'b0;
    pix_next = 1'b1;
    if (counter_H < 10'(H_ACTIVE) && counter_V < 10'(V_ACTIVE)) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (!found && active[i].valid && active[i].column == pix_col) begin
          found    = 1'b1;
          pix_next = active[i].flip ? active[i].data[3'd7 - pix_idx]
                                    : active[i].data[pix_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      colour <= 1'b1;
    end else begin
      if (shadow_clear) begin
        for (int i = 0; i < SLOTS; i++) begin
          shadow[i] <= '0;
        end
      end else if (wr_en) begin
        shadow[wr_idx] <= wr_slot;
      end
      if (swap) begin
        for (int i = 0; i < SLOTS; i++) begin
          active[i] <= shadow[i];
        end
      end
      colour <= pix_next;
    end
  end

endmodule

// File: rtl/sprite_line_compositor.sv
// Scans the entity bus during horizontal blanking, fetches sprite rows for the
// next line from the sprite ROM and hands them to the slot bank for display.
module sprite_line_compositor
  import fb_pkg::*;
#(
  parameter int NUM_ENTITIES = 9,
  parameter int SLOTS        = 4,
  parameter int UPSCALE      = 5,
  parameter int TILE_PX      = 8,
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int TILES_H      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_ENTITIES*ENTITY_W-1:0] entities,
  input  logic [NUM_ENTITIES-1:0]          flip_mask,
  input  logic [9:0]                       counter_H,
  input  logic [9:0]                       counter_V,
  output logic                             rom_req,
  output logic [3:0]                       rom_sprite_id,
  output logic [1:0]                       rom_orientation,
  output logic [2:0]                       rom_line,
  input  logic [7:0]                       rom_data,
  output logic                             colour,
  output logic                             overflow
);

  localparam int ENT_IDX_W  = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;
  localparam int SLOT_IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W      = $clog2(SLOTS + 1);
  localparam logic [9:0] TILE_LEN  = 10'(UPSCALE * TILE_PX);
  localparam logic [9:0] UPSCALE_V = 10'(UPSCALE);
  localparam logic [7:0] TILES_H_V = 8'(TILES_H);

  if (NUM_ENTITIES + 3 > H_TOTAL - H_ACTIVE) begin : g_scan_window_check
    $error("sprite_line_compositor: entity scan does not fit in horizontal blanking");
  end

  fetch_state_t             state, state_next;
  logic [ENT_IDX_W-1:0]     scan_idx;
  logic [CNT_W-1:0]         next_slot;
  logic                     pend_valid;
  logic [SLOT_IDX_W-1:0]    pend_slot;
  logic [3:0]               pend_col;
  logic                     pend_flip;
  logic                     shadow_ovf;

  logic [ENTITY_W-1:0]      ent;
  logic [ID_W-1:0]          ent_id;
  logic [LOC_W-1:0]         ent_loc;
  logic [7:0]               ent_row;
  logic [3:0]               ent_col;
  logic [9:0]               tgt_line;
  logic [7:0]               tgt_row;
  logic                     fetch_en, hit, has_free, scan_last, start_scan, swap;
  slot_t                    wr_slot;

  assign ent       = entities[ENTITY_W*int'(scan_idx) +: ENTITY_W];
  assign ent_id    = ent[ID_LSB +: ID_W];
  assign ent_loc   = ent[LOC_LSB +: LOC_W];
  assign ent_row   = ent_loc / TILES_H_V;
  assign ent_col   = 4'(ent_loc % TILES_H_V);

  assign tgt_line  = (counter_V == 10'(V_TOTAL - 1)) ? 10'd0 : counter_V + 10'd1;
  assign tgt_row   = 8'(tgt_line / TILE_LEN);
  assign fetch_en  = tgt_line < 10'(V_ACTIVE);

  assign hit        = fetch_en && (ent_id != ENTITY_NONE) && (ent_row == tgt_row);
  assign has_free   = next_slot < CNT_W'(SLOTS);
  assign scan_last  = scan_idx == ENT_IDX_W'(NUM_ENTITIES - 1);
  assign start_scan = (state == ST_IDLE) && (counter_H == 10'(H_ACTIVE));
  assign swap       = (state == ST_DONE) && (counter_H == 10'(H_TOTAL - 1));

  assign rom_sprite_id   = ent_id;
  assign rom_orientation = ent[ORI_LSB +: ORI_W];
  assign rom_line        = 3'((tgt_line % TILE_LEN) / UPSCALE_V);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rom_req    = 1'b0;
    case (state)
      ST_IDLE:  if (start_scan) state_next = ST_SCAN;
      ST_SCAN: begin
        rom_req = hit && has_free;
        if (scan_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  if (swap) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The ROM answers a cycle after the strobe, so slot/column/flip ride along
  // in the pending registers until the data arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx   <= '0;
      next_slot  <= '0;
      pend_valid <= 1'b0;
      pend_slot  <= '0;
      pend_col   <= '0;
      pend_flip  <= 1'b0;
      shadow_ovf <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (start_scan) begin
        scan_idx   <= '0;
        next_slot  <= '0;
        shadow_ovf <= 1'b0;
      end else if (state == ST_SCAN) begin
        if (!scan_last) scan_idx <= scan_idx + ENT_IDX_W'(1);
        if (hit) begin
          if (has_free) next_slot <= next_slot + CNT_W'(1);
          else          shadow_ovf <= 1'b1;
        end
      end
      pend_valid <= rom_req;
      pend_slot  <= SLOT_IDX_W'(next_slot);
      pend_col   <= ent_col;
      pend_flip  <= flip_mask[scan_idx];
      if (swap) overflow <= shadow_ovf;
    end
  end

  assign wr_slot = '{valid: 1'b1, column: pend_col, flip: pend_flip, data: rom_data};

  line_slot_bank #(
    .SLOTS    (SLOTS),
    .UPSCALE  (UPSCALE),
    .TILE_PX  (TILE_PX),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .IDX_W    (SLOT_IDX_W)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .shadow_clear (start_scan),
    .wr_en        (pend_valid),
    .wr_idx       (pend_slot),
    .wr_slot      (wr_slot),
    .swap         (swap),
    .counter_H    (counter_H),
    .counter_V    (counter_V),
    .colour       (colour)
  );

endmodule

// File: tb/tb_sprite_line_compositor.sv
// Directed bench for sprite_line_compositor: drives scan counters line by line,
// models a one-cycle-latency sprite ROM and checks fetches and composited pixels.
module tb_sprite_line_compositor;

  localparam int NE = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NE*14-1:0] entities;
  logic [NE-1:0]    flip_mask = '0;
  logic [9:0]       counter_H = '0;
  logic [9:0]       counter_V = '0;
  logic             rom_req;
  logic [3:0]       rom_sprite_id;
  logic [1:0]       rom_orientation;
  logic [2:0]       rom_line;
  logic [7:0]       rom_data = 8'h5A;
  logic             colour;
  logic             overflow;

  logic [7:0] rom_table [16];
  logic       col_seen [800];
  int         cur_h = 0;
  int         checks = 0;
  int         errors = 0;
  int         req_count = 0;
  logic [3:0] req_ids [$];
  logic [2:0] last_line = '0;
  logic [1:0] last_ori = '0;

  sprite_line_compositor dut (
    .clk             (clk),
    .reset           (reset),
    .entities        (entities),
    .flip_mask       (flip_mask),
    .counter_H       (counter_H),
    .counter_V       (counter_V),
    .rom_req         (rom_req),
    .rom_sprite_id   (rom_sprite_id),
    .rom_orientation (rom_orientation),
    .rom_line        (rom_line),
    .rom_data        (rom_data),
    .colour          (colour),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Junk outside the answer cycle exposes a capture on the wrong edge.
  always @(posedge clk) rom_data <= rom_req ? rom_table[rom_sprite_id] : 8'h5A;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entity(input int k, input logic [3:0] id, input logic [1:0] ori,
                            input logic [7:0] loc);
    entities[k*14 +: 14] = {id, ori, loc};
  endtask

  task automatic clear_entities();
    for (int k = 0; k < NE; k++) set_entity(k, 4'hF, 2'd0, 8'h00);
  endtask

  function automatic logic [3:0] req_id(input int i);
    return (i < req_ids.size()) ? req_ids[i] : 4'hx;
  endfunction

  // One step per clock: record the registered colour for the previous column,
  // then present the next counters and log any ROM strobe they produce.
  task automatic apply_stimulus(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      @(posedge clk);
      #1;
      col_seen[cur_h] = colour;
      counter_V = 10'(v);
      counter_H = 10'(h);
      cur_h = h;
      #1;
      if (rom_req === 1'b1) begin
        req_count++;
        req_ids.push_back(rom_sprite_id);
        last_line = rom_line;
        last_ori = rom_orientation;
      end
    end
  endtask

  task automatic full_line(input int v);
    req_count = 0;
    req_ids.delete();
    apply_stimulus(v, 0, 799);
  endtask

  task automatic check_tile(input string tag, input int col, input logic [7:0] data,
                            input logic flip);
    for (int p = 0; p < 8; p++) begin
      for (int s = 0; s < 5; s++) begin
        check_output(tag, 32'(col_seen[col*40 + p*5 + s]), 32'(flip ? data[7-p] : data[p]));
      end
    end
  endtask

  task automatic check_white_except(input string tag, input int lo, input int hi);
    int cnt;
    cnt = 0;
    for (int h = 0; h < 640; h++) begin
      if (!(h >= lo*40 && h <= hi*40 + 39) && col_seen[h] !== 1'b1) cnt++;
    end
    check_output(tag, cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_table[i] = 8'h00;
    for (int i = 0; i < 800; i++) col_seen[i] = 1'b1;
    clear_entities();

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_colour", 32'(colour), 1);
    check_output("reset_rom_req", 32'(rom_req), 0);
    check_output("reset_overflow", 32'(overflow), 0);
    reset = 1'b1;

    $display("[TB] single sprite");
    set_entity(0, 4'd3, 2'd0, 8'h12);
    rom_table[3] = 8'b10100101;
    full_line(39);
    check_output("s1_req_count", req_count, 1);
    check_output("s1_req_id", 32'(req_id(0)), 3);
    check_output("s1_rom_line", 32'(last_line), 0);
    full_line(40);
    check_tile("s1_tile", 2, 8'b10100101, 1'b0);
    check_white_except("s1_background", 2, 2);
    check_output("s1_overflow", 32'(overflow), 0);

    $display("[TB] flip");
    flip_mask[0] = 1'b1;
    rom_table[3] = 8'h01;
    full_line(39);
    full_line(40);
    check_tile("s2_flip_tile", 2, 8'h01, 1'b1);
    check_output("s2_px114_black", 32'(col_seen[114]), 0);
    check_output("s2_px115_white", 32'(col_seen[115]), 1);
    check_white_except("s2_background", 2, 2);

    $display("[TB] row index and orientation");
    flip_mask[0] = 1'b0;
    set_entity(0, 4'd3, 2'd2, 8'h12);
    full_line(46);
    check_output("rl_req_count", req_count, 1);
    check_output("rl_rom_line", 32'(last_line), 1);
    check_output("rl_orientation", 32'(last_ori), 2);

    $display("[TB] priority");
    set_entity(0, 4'd3, 2'd0, 8'h12);
    set_entity(4, 4'd5, 2'd0, 8'h12);
    rom_table[3] = 8'h00;
    rom_table[5] = 8'hFF;
    full_line(39);
    check_output("s3_req_count", req_count, 2);
    check_output("s3_req_id0", 32'(req_id(0)), 3);
    check_output("s3_req_id1", 32'(req_id(1)), 5);
    full_line(40);
    check_tile("s3_priority_tile", 2, 8'h00, 1'b0);

    $display("[TB] overflow");
    clear_entities();
    for (int k = 0; k < 6; k++) begin
      set_entity(k, 4'(k + 1), 2'd0, 8'(8'h20 + k));
      rom_table[k + 1] = 8'h00;
    end
    full_line(79);
    check_output("s4_req_count", req_count, 4);
    for (int i = 0; i < 4; i++) check_output("s4_req_id", 32'(req_id(i)), 32'(i + 1));
    full_line(80);
    check_output("s4_overflow_set", 32'(overflow), 1);
    check_tile("s4_tile_col0", 0, 8'h00, 1'b0);
    check_tile("s4_tile_col3", 3, 8'h00, 1'b0);
    check_white_except("s4_dropped_white", 0, 3);
    full_line(119);
    check_output("s4_row3_no_req", req_count, 0);
    apply_stimulus(120, 0, 0);
    check_output("s4_overflow_clear", 32'(overflow), 0);

    $display("[TB] frame wrap and empty");
    clear_entities();
    set_entity(0, 4'd7, 2'd0, 8'h03);
    rom_table[7] = 8'hAA;
    full_line(524);
    check_output("s5_wrap_req_count", req_count, 1);
    check_output("s5_wrap_rom_line", 32'(last_line), 0);
    full_line(0);
    check_tile("s5_wrap_tile", 3, 8'hAA, 1'b0);
    check_white_except("s5_wrap_background", 3, 3);
    set_entity(0, 4'd7, 2'd0, 8'hC3);
    full_line(479);
    check_output("s5_vblank_no_req", req_count, 0);
    clear_entities();
    full_line(10);
    check_output("s5_empty_no_req", req_count, 0);
    full_line(11);
    check_white_except("s5_empty_white", -1, -2);

    $display("[TB] reset mid-scan");
    set_entity(4, 4'd3, 2'd0, 8'h12);
    rom_table[3] = 8'h00;
    full_line(39);
    req_count = 0;
    req_ids.delete();
    apply_stimulus(39, 0, 645);
    check_output("s6_req_before_reset", 32'(rom_req), 1);
    reset = 1'b0;
    #1;
    check_output("s6_reset_rom_req", 32'(rom_req), 0);
    check_output("s6_reset_colour", 32'(colour), 1);
    apply_stimulus(39, 646, 650);
    reset = 1'b1;
    apply_stimulus(39, 651, 799);
    full_line(40);
    check_white_except("s6_line_after_release", -1, -2);
    check_output("s6_refetch_req_count", req_count, 1);
    full_line(41);
    check_tile("s6_recovered_tile", 2, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
